// File: rtl/speed_mon_pkg.sv
// Shared types, default parameters and helpers for the speed window monitor.
package speed_mon_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_CNT_W      = 9;
    localparam int DEF_THRESH     = 33;
    localparam int DEF_WINDOW_SEC = 10;
    localparam int DEF_SEC_W      = 5;
    localparam int DEF_SAT_MAX    = 9;
    localparam int DEF_OUT_W      = 16;
    localparam bit DEF_AUTO_RESTART = 1'b0;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value < max_value) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/speed_window_monitor_pulse_edge_counter.sv
// Rising-edge detector on the sensor level feeding a saturating per-second counter.
module pulse_edge_counter
    import speed_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] eff
);

    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic             pulse_q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_edge;

    assign pulse_edge = pulse_in & ~pulse_q_reg;
    // eff folds a same-cycle edge into the count so a tick can close the second with it.
    assign eff = pulse_edge ? CNT_W'(sat_inc(32'(cnt_reg), CNT_MAX)) : cnt_reg;
    assign cnt = cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            pulse_q_reg <= pulse_in;
            if (clear) begin
                cnt_reg <= '0;
            end else if (count_en && pulse_edge) begin
                cnt_reg <= eff;
            end
        end
    end

endmodule

// File: rtl/speed_window_monitor.sv
// Counts sensor pulses per second over a window of seconds and scores the "fast" seconds.
module speed_window_monitor
    import speed_mon_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int THRESH       = DEF_THRESH,
    parameter int WINDOW_SEC   = DEF_WINDOW_SEC,
    parameter int SEC_W        = DEF_SEC_W,
    parameter int SAT_MAX      = DEF_SAT_MAX,
    parameter int OUT_W        = DEF_OUT_W,
    parameter bit AUTO_RESTART = DEF_AUTO_RESTART
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pulse_in,
    input  logic             sec_tick,
    output logic [OUT_W-1:0] hits_live,
    output logic [OUT_W-1:0] speed_check,
    output logic [CNT_W-1:0] last_rate,
    output logic [CNT_W-1:0] peak_rate,
    output logic             window_active,
    output logic             window_done
);

    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(WINDOW_SEC - 1);

    generate
        if (THRESH > (1 << CNT_W) - 1) begin : g_thresh_check
            $error("THRESH does not fit in the per-second counter");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [SEC_W-1:0] sec_count_reg;
    logic [OUT_W-1:0] hits_live_reg, speed_check_reg, hits_next;
    logic [CNT_W-1:0] last_rate_reg, peak_rate_reg, peak_next;
    logic             window_done_reg;
    logic [CNT_W-1:0] cnt, eff;
    logic             tick, window_end, clear_live, cnt_clear, cnt_en;

    // start=0 outranks sec_tick, so a tick only counts while the window stays enabled.
    assign tick       = (state_reg == RUN) && start && sec_tick;
    assign window_end = tick && (sec_count_reg == LAST_SEC);
    assign clear_live = ((state_reg == IDLE) && start) || ((state_reg != IDLE) && !start);
    assign cnt_clear  = (state_reg != RUN) || !start || sec_tick;
    assign cnt_en     = (state_reg == RUN);

    assign hits_next = (eff >= THRESH_V) ? OUT_W'(sat_inc(32'(hits_live_reg), 32'(SAT_MAX)))
                                         : hits_live_reg;
    assign peak_next = (eff > peak_rate_reg) ? eff : peak_rate_reg;

    pulse_edge_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .cnt      (cnt),
        .eff      (eff)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (!start)                          state_next = IDLE;
                else if (window_end && !AUTO_RESTART) state_next = DONE;
            end
            DONE: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            sec_count_reg   <= '0;
            hits_live_reg   <= '0;
            speed_check_reg <= '0;
            last_rate_reg   <= '0;
            peak_rate_reg   <= '0;
            window_done_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            window_done_reg <= 1'b0;
            if (clear_live) begin
                sec_count_reg <= '0;
                hits_live_reg <= '0;
                last_rate_reg <= '0;
                peak_rate_reg <= '0;
            end else if (tick) begin
                last_rate_reg <= eff;
                if (window_end) begin
                    speed_check_reg <= hits_next;
                    window_done_reg <= 1'b1;
                    if (AUTO_RESTART) begin
                        sec_count_reg <= '0;
                        hits_live_reg <= '0;
                        peak_rate_reg <= '0;
                    end else begin
                        hits_live_reg <= hits_next;
                        peak_rate_reg <= peak_next;
                    end
                end else begin
                    sec_count_reg <= sec_count_reg + 1'b1;
                    hits_live_reg <= hits_next;
                    peak_rate_reg <= peak_next;
                end
            end
        end
    end

    assign hits_live     = hits_live_reg;
    assign speed_check   = speed_check_reg;
    assign last_rate     = last_rate_reg;
    assign peak_rate     = peak_rate_reg;
    assign window_active = (state_reg == RUN);
    assign window_done   = window_done_reg;

endmodule

// File: tb/tb_speed_window_monitor.sv
// Directed bench: default monitor, an auto-restart copy and a narrow-counter copy share one stimulus.
module tb_speed_window_monitor;

    logic clk = 1'b0;
    logic reset, start, pulse_in, sec_tick;

    logic [15:0] hits0, spd0, hits1, spd1, hits2, spd2;
    logic [8:0]  last0, peak0, last1, peak1;
    logic [3:0]  last2, peak2;
    logic        act0, done0, act1, done1, act2, done2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    speed_window_monitor dut0 (
        .clk(clk), .reset(reset), .start(start), .pulse_in(pulse_in), .sec_tick(sec_tick),
        .hits_live(hits0), .speed_check(spd0), .last_rate(last0), .peak_rate(peak0),
        .window_active(act0), .window_done(done0)
    );

    speed_window_monitor #(.AUTO_RESTART(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pulse_in(pulse_in), .sec_tick(sec_tick),
        .hits_live(hits1), .speed_check(spd1), .last_rate(last1), .peak_rate(peak1),
        .window_active(act1), .window_done(done1)
    );

    speed_window_monitor #(.CNT_W(4), .THRESH(10)) dut2 (
        .clk(clk), .reset(reset), .start(start), .pulse_in(pulse_in), .sec_tick(sec_tick),
        .hits_live(hits2), .speed_check(spd2), .last_rate(last2), .peak_rate(peak2),
        .window_active(act2), .window_done(done2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; pulse_in = 1'b0; sec_tick = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    // n edges, then a tick; tick_edge puts one more edge on the tick cycle itself.
    task automatic second(input int n, input bit tick_edge);
        for (int i = 0; i < n; i++) begin
            pulse_in = 1'b1; cyc();
            pulse_in = 1'b0; cyc();
        end
        sec_tick = 1'b1;
        pulse_in = tick_edge;
        cyc();
        sec_tick = 1'b0;
        pulse_in = 1'b0;
        if (tick_edge) cyc();
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_hits", hits0, 0);
        chk("rst_speed", spd0, 0);
        chk("rst_last", last0, 0);
        chk("rst_peak", peak0, 0);
        chk("rst_active", act0, 0);
        chk("rst_done", done0, 0);

        // window of 40-edge seconds
        start = 1'b1; cyc();
        chk("s1_active", act0, 1);
        for (int k = 1; k <= 10; k++) begin
            second(40, 1'b0);
            $display("s1 tick %0d: hits=%0d done=%0d last=%0d", k, hits0, done0, last0);
            chk("s1_done0", done0, (k == 10) ? 1 : 0);
            chk("s1_done1", done1, (k == 10) ? 1 : 0);
            if (k == 1) begin
                chk("s1_hits_first", hits0, 1);
                chk("cnt4_sat_last", last2, 15);
            end
        end
        chk("s1_speed", spd0, 9);
        chk("s1_hits", hits0, 9);
        chk("s1_last", last0, 40);
        chk("s1_peak", peak0, 40);
        chk("s1_active_done", act0, 0);
        chk("ar_speed_a", spd1, 9);
        chk("ar_hits_cleared", hits1, 0);
        chk("ar_peak_cleared", peak1, 0);
        chk("ar_last_kept", last1, 40);
        chk("ar_active", act1, 1);
        cyc();
        chk("s1_done_pulse_end", done0, 0);

        // DONE holds for dut0 while the auto-restart copy runs window B of empty seconds
        for (int k = 1; k <= 10; k++) begin
            second(0, 1'b0);
            $display("wB tick %0d: ar_done=%0d ar_speed=%0d", k, done1, spd1);
            chk("ar_done_b", done1, (k == 10) ? 1 : 0);
            if (k == 1) begin
                chk("done_hold_last", last0, 40);
                chk("done_hold_hits", hits0, 9);
                chk("done_hold_wdone", done0, 0);
            end
        end
        chk("ar_speed_b", spd1, 0);
        chk("done_hold_speed", spd0, 9);

        // abort from DONE, restart, abort again after the 4th tick with a colliding tick
        start = 1'b0; cyc();
        chk("ab_idle_last", last0, 0);
        chk("ab_idle_speed", spd0, 9);
        start = 1'b1; cyc();
        for (int k = 1; k <= 4; k++) second(40, 1'b0);
        chk("ab_hits4", hits0, 4);
        start = 1'b0; sec_tick = 1'b1; pulse_in = 1'b1;
        cyc();
        sec_tick = 1'b0; pulse_in = 1'b0;
        $display("abort: hits=%0d last=%0d peak=%0d speed=%0d", hits0, last0, peak0, spd0);
        chk("ab_hits", hits0, 0);
        chk("ab_last", last0, 0);
        chk("ab_peak", peak0, 0);
        chk("ab_speed", spd0, 9);
        chk("ab_done", done0, 0);
        chk("ab_active", act0, 0);

        // alternating 32 / 33 edges around the threshold
        do_reset();
        start = 1'b1; cyc();
        for (int k = 1; k <= 10; k++) begin
            second((k % 2 == 1) ? 32 : 33, 1'b0);
            if (k == 1) chk("alt_hits_32", hits0, 0);
        end
        $display("alt: speed=%0d peak=%0d", spd0, peak0);
        chk("alt_speed", spd0, 5);
        chk("alt_peak", peak0, 33);
        chk("alt_last", last0, 33);

        // 33rd edge lands on the tick cycle
        do_reset();
        start = 1'b1; cyc();
        second(32, 1'b1);
        $display("tick edge: hits=%0d last=%0d", hits0, last0);
        chk("te_hits", hits0, 1);
        chk("te_last", last0, 33);
        second(0, 1'b0);
        chk("te_next_last", last0, 0);
        chk("te_next_hits", hits0, 1);

        // narrow counter saturation, then a held-high level
        do_reset();
        start = 1'b1; cyc();
        second(20, 1'b0);
        $display("cnt4: last=%0d wide last=%0d", last2, last0);
        chk("cnt4_last20", last2, 15);
        chk("wide_last20", last0, 20);
        pulse_in = 1'b1;
        for (int i = 0; i < 50; i++) cyc();
        pulse_in = 1'b0; cyc();
        sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
        $display("held level: last=%0d", last0);
        chk("held_last", last0, 1);
        chk("held_last_cnt4", last2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/speed_window_monitor.md
Name: speed_window_monitor

Overview:
- Parametrised successor to the lab speed checker. Counts step/light pulses in each one-second interval of a measurement window and counts the "fast" seconds, i.e. those whose pulse count reaches a threshold.
- Single clock domain: the sensor pulse arrives as a synchronous level and is edge-detected internally; the second timebase arrives as a 1-cycle strobe.
- Publishes live hit count, last-second rate, peak rate and a latched per-window result to the display/score logic.

Parameters:
- CNT_W, 9: width of per-second pulse counter; counter saturates at 2^CNT_W-1.
- THRESH, 33: minimum pulses in a second for that second to count as a hit.
- WINDOW_SEC, 10: seconds per measurement window, >=1.
- SEC_W, 5: width of seconds counter; must hold WINDOW_SEC-1.
- SAT_MAX, 9: saturation value of the hit count.
- OUT_W, 16: width of hit outputs; SAT_MAX < 2^OUT_W.
- AUTO_RESTART, 0: 0 = stop in DONE after one window; 1 = start the next window immediately.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; highest priority
- start  in  1  level enable; low aborts/clears the live measurement
- pulse_in  in  1  sensor pulse level, synchronous to clk; each rising edge = 1 pulse
- sec_tick  in  1  1-cycle strobe marking the end of each second
- hits_live  out  OUT_W  hits counted so far in the current window
- speed_check  out  OUT_W  final hit count of the last completed window
- last_rate  out  CNT_W  pulse count of the most recently closed second
- peak_rate  out  CNT_W  maximum last_rate seen in the current window
- window_active  out  1  high while state == RUN
- window_done  out  1  1-cycle pulse when a window completes

Behaviour:
- Reset, on any cycle with reset=1:
  - state=IDLE; every register and output = 0, including the pulse_in delay flop.
- Edge detect: edge = pulse_in & ~pulse_q. pulse_q updates every cycle in all states. A held-high level counts once.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1:
  - next state RUN.
  - Clear pulse count, sec_count, hits_live, last_rate and peak_rate.
  - Edges and sec_tick in this cycle are ignored.
- RUN, each cycle:
  - if edge and no sec_tick, cnt = sat(cnt+1).
- RUN, sec_tick=1:
  - eff = sat(cnt+edge); an edge in the tick cycle belongs to the closing second.
  - last_rate<=eff; peak_rate<=max(peak_rate,eff).
  - if eff>=THRESH and hits_live<SAT_MAX, hits_live+1.
  - cnt<=0; sec_count+1.
- RUN, window end (sec_tick with sec_count==WINDOW_SEC-1):
  - speed_check<=final hits (this tick's hit included); window_done=1 for exactly this cycle.
  - AUTO_RESTART=0: next state DONE.
  - AUTO_RESTART=1: stay in RUN; clear cnt, sec_count, hits_live and peak_rate on the same edge. last_rate keeps the final second.
- The partial second between entering RUN and the first sec_tick counts as a full second.
- DONE: all outputs hold; edges and sec_tick ignored; window_active=0.
- start=0 in RUN or DONE:
  - next cycle IDLE.
  - Clear cnt, sec_count, hits_live, last_rate and peak_rate.
  - speed_check retains the last completed result; no window_done.
- start=0 takes priority over a simultaneous sec_tick: no hit is counted and no completion occurs.
- Saturation:
  - cnt stops at 2^CNT_W-1, no wrap.
  - hits_live stops at SAT_MAX.
- Latency: all outputs are registered; an effect appears one clk after the causing input.
- Elaboration check: THRESH <= 2^CNT_W-1.

Decomposition:
- Package speed_mon_pkg holds:
  - state typedef {IDLE, RUN, DONE};
  - default parameter constants;
  - a saturating-increment helper function.
- Sub-module pulse_edge_counter (parameter CNT_W) holds:
  - edge detect;
  - saturating counter with clear input and count-enable input;
  - eff output combining cnt with the same-cycle edge.
- FSM, hit logic and result latches stay in the top module.

Test Plan:
- Reset, start=1, 40 edges per second for 10 ticks:
  - hits_live saturates at 9.
  - window_done pulses once on the 10th tick; speed_check=9; last_rate=40; peak_rate=40.
  - state DONE, window_active=0.
- Seconds alternating 32 and 33 edges for 10 ticks: speed_check=5; peak_rate=33.
- 32 edges, then a 33rd edge on the same cycle as sec_tick:
  - second counted as a hit; last_rate=33.
  - next second starts from 0 (next tick with 0 edges gives last_rate=0).
- After a completed window (speed_check=9), restart and drop start after the 4th tick:
  - next cycle IDLE; hits_live=0, last_rate=0, peak_rate=0.
  - speed_check stays 9; no window_done.
- AUTO_RESTART=1, window A all 40-edge seconds, window B all 0-edge seconds:
  - window_done pulses exactly 10 ticks apart.
  - speed_check goes 9 then 0; hits_live back to 0 on the cycle after A completes.
- CNT_W=4, 20 edges in one second: last_rate=15 (saturated). Separately, pulse_in held high for 50 cycles counts 1.
